imem_loader: RTL and testbench

- Boot-time controller that fills the single-cycle core's program memory from a byte stream, for example a UART receiver, in place of a fixed text.data image.
- Parses a 2-byte word-count header, assembles little-endian 32-bit instructions and issues one write per word at the program memory's word-aligned addresses.
- Holds the core in reset until the image is complete.
- Sits between the byte source, the writable program memory port and the core reset.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_word_assembler.sv | 41 ++++
 rtl/imem_loader.sv | 159 +++++++++++++++
 tb/tb_imem_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the boot-time program memory loader.
// TEXT_BASE_DEFAULT is also used by the program memory and the PC reset value.
package imem_loader_pkg;

    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_HDR_LO  = 3'd1;
    localparam state_t ST_HDR_HI  = 3'd2;
    localparam state_t ST_CHECK   = 3'd3;
    localparam state_t ST_COLLECT = 3'd4;
    localparam state_t ST_WRITE   = 3'd5;
    localparam state_t ST_DONE    = 3'd6;
    localparam state_t ST_ERROR   = 3'd7;

    function automatic logic in_session(input state_t st);
        return (st == ST_HDR_LO) || (st == ST_HDR_HI) || (st == ST_CHECK) ||
               (st == ST_COLLECT) || (st == ST_WRITE);
    endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Little-endian byte-to-word assembler: byte index counter plus insert register.
// Word_o already contains the byte being loaded this cycle.
module imem_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        Load_i,
    input  logic        Clear_i,
    input  logic [7:0]  Byte_i,
    output logic [31:0] Word_o,
    output logic        Word_ready_o
);

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        if (Clear_i) begin
            byte_idx_d = '0;
            word_d     = '0;
        end else if (Load_i) begin
            word_d[8*byte_idx_q +: 8] = Byte_i;
            byte_idx_d                = byte_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_idx_q <= '0;
            word_q     <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
        end
    end

    assign Word_o       = word_d;
    assign Word_ready_o = Load_i && !Clear_i && (byte_idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header-counted byte stream -> program memory word writes,
// holding the core in reset until the whole image has been written.
//
// state   | meaning
// IDLE    | waiting for first Start_i after reset
// HDR_LO  | waiting for word-count low byte
// HDR_HI  | waiting for word-count high byte
// CHECK   | validating count against MEMORY_DEPTH
// COLLECT | gathering 4 bytes of the current word
// WRITE   | one-cycle program memory write
// DONE    | image loaded, core released
// ERROR   | bad header, core stays in reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = TEXT_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start_i,
    input  logic [7:0]            Byte_i,
    input  logic                  Byte_valid_i,
    output logic                  Byte_ready_o,
    output logic                  Mem_we_o,
    output logic [DATA_WIDTH-1:0] Mem_addr_o,
    output logic [DATA_WIDTH-1:0] Mem_wdata_o,
    output logic                  Cpu_rst_n_o,
    output logic                  Busy_o,
    output logic                  Done_o,
    output logic                  Error_o
);

    localparam logic [15:0] DEPTH_W = 16'(MEMORY_DEPTH);

    state_t                  state_q, state_d;
    logic [15:0]             count_q, count_d;
    logic [15:0]             word_idx_q, word_idx_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic                    byte_xfer;
    logic                    start_acc;
    logic                    asm_load;
    logic                    asm_clear;
    logic [31:0]             asm_word;
    logic                    asm_word_ready;

    assign Byte_ready_o = (state_q == ST_HDR_LO) || (state_q == ST_HDR_HI) ||
                          (state_q == ST_COLLECT);
    assign byte_xfer    = Byte_valid_i && Byte_ready_o;
    assign start_acc    = Start_i && !busy_q;
    assign asm_load     = (state_q == ST_COLLECT) && byte_xfer;
    assign asm_clear    = (state_q == ST_CHECK) ||
                          (((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                            (state_q == ST_ERROR)) && start_acc);

    imem_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .Load_i       (asm_load),
        .Clear_i      (asm_clear),
        .Byte_i       (Byte_i),
        .Word_o       (asm_word),
        .Word_ready_o (asm_word_ready)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_acc) state_d = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                if (byte_xfer) begin
                    count_d[7:0] = Byte_i;
                    state_d      = ST_HDR_HI;
                end
            end
            ST_HDR_HI: begin
                if (byte_xfer) begin
                    count_d[15:8] = Byte_i;
                    state_d       = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((count_q == 16'd0) || (count_q > DEPTH_W)) begin
                    state_d = ST_ERROR;
                end else begin
                    word_idx_d = '0;
                    state_d    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (asm_word_ready) begin
                    addr_d  = TEXT_BASE + DATA_WIDTH'({word_idx_q, 2'b00});
                    wdata_d = DATA_WIDTH'(asm_word);
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (word_idx_q == (count_q - 16'd1)) begin
                    state_d = ST_DONE;
                end else begin
                    word_idx_d = word_idx_q + 16'd1;
                    state_d    = ST_COLLECT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags hand over in the same edge: Busy_o stays up through the
    // CHECK/WRITE exit cycle so it falls exactly when Done_o or Error_o rises.
    always_comb begin
        busy_d  = in_session(state_d) || (state_q == ST_CHECK) || (state_q == ST_WRITE);
        done_d  = (state_q == ST_DONE) && (state_d == ST_DONE);
        error_d = (state_q == ST_ERROR) && (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            addr_q     <= TEXT_BASE;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign Mem_we_o    = (state_q == ST_WRITE);
    assign Mem_addr_o  = addr_q;
    assign Mem_wdata_o = wdata_q;
    assign Cpu_rst_n_o = done_q;
    assign Busy_o      = busy_q;
    assign Done_o      = done_q;
    assign Error_o     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: header table, randomized images and
// hand-written latency, reset and restart sequences.
module tb_imem_loader;

    localparam logic [31:0] TB_BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start_i;
    logic [7:0]  Byte_i;
    logic        Byte_valid_i;
    logic        Byte_ready_o;
    logic        Mem_we_o;
    logic [31:0] Mem_addr_o;
    logic [31:0] Mem_wdata_o;
    logic        Cpu_rst_n_o;
    logic        Busy_o;
    logic        Done_o;
    logic        Error_o;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .Start_i      (Start_i),
        .Byte_i       (Byte_i),
        .Byte_valid_i (Byte_valid_i),
        .Byte_ready_o (Byte_ready_o),
        .Mem_we_o     (Mem_we_o),
        .Mem_addr_o   (Mem_addr_o),
        .Mem_wdata_o  (Mem_wdata_o),
        .Cpu_rst_n_o  (Cpu_rst_n_o),
        .Busy_o       (Busy_o),
        .Done_o       (Done_o),
        .Error_o      (Error_o)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    logic [31:0] img[$];
    logic        we_prev = 1'b0;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        bit         gaps;
        bit         exp_err;
        int         exp_writes;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Write monitor: a write lasts exactly one cycle and never overlaps byte intake.
    always @(negedge clk) begin
        if (Mem_we_o) begin
            cap_addr.push_back(Mem_addr_o);
            cap_data.push_back(Mem_wdata_o);
            check("we_single_cycle", {31'd0, we_prev}, 32'd0);
            check("we_not_ready", {31'd0, Byte_ready_o}, 32'd0);
        end
        we_prev = Mem_we_o;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        Byte_valid_i = 1'b0;
        repeat (gap) @(negedge clk);
        Byte_i       = b;
        Byte_valid_i = 1'b1;
        n = 0;
        while (!Byte_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errs++;
            checks++;
            $display("FAIL byte_timeout: ready never seen for byte %h", b);
        end
        @(negedge clk);
        Byte_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        Start_i = 1'b1;
        @(negedge clk);
        Start_i = 1'b0;
    endtask

    function automatic int pick_gap(input bit gaps);
        if (!gaps) return 0;
        return ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : 0;
    endfunction

    task automatic send_image(input bit gaps);
        foreach (img[i])
            for (int k = 0; k < 4; k++)
                send_byte(8'((img[i] >> (8 * k)) & 32'hFF), pick_gap(gaps));
    endtask

    task automatic wait_done_or_error();
        int n = 0;
        while (!Done_o && !Error_o && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Reference: word i of the image lands at TEXT_BASE + 4*i, unchanged.
    task automatic compare_writes(input string tag, input int exp_n);
        check({tag, "_nwrites"}, 32'(cap_addr.size()), 32'(exp_n));
        for (int i = 0; i < exp_n && i < cap_addr.size(); i++) begin
            check({tag, "_addr"}, cap_addr[i], TB_BASE + 32'(i) * 32'd4);
            check({tag, "_data"}, cap_data[i], img[i]);
        end
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        cap_addr.delete();
        cap_data.delete();
        img.delete();
        for (int i = 0; i < v.exp_writes; i++) img.push_back($urandom);
        pulse_start();
        check({tag, "_start_cpu_rst"}, {31'd0, Cpu_rst_n_o}, 32'd0);
        check({tag, "_start_done"}, {31'd0, Done_o}, 32'd0);
        check({tag, "_start_error"}, {31'd0, Error_o}, 32'd0);
        check({tag, "_start_busy"}, {31'd0, Busy_o}, 32'd1);
        send_byte(v.lo, pick_gap(v.gaps));
        send_byte(v.hi, pick_gap(v.gaps));
        if (!v.exp_err) send_image(v.gaps);
        wait_done_or_error();
        check({tag, "_error"}, {31'd0, Error_o}, {31'd0, v.exp_err});
        check({tag, "_done"}, {31'd0, Done_o}, {31'd0, !v.exp_err});
        check({tag, "_cpu_rst_n"}, {31'd0, Cpu_rst_n_o}, {31'd0, !v.exp_err});
        check({tag, "_busy"}, {31'd0, Busy_o}, 32'd0);
        compare_writes(tag, v.exp_writes);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{8'h01, 8'h00, 1'b0, 1'b0, 1});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b1, 0});
        vecs.push_back('{8'h21, 8'h00, 1'b0, 1'b1, 0});
        vecs.push_back('{8'h02, 8'h00, 1'b1, 1'b0, 2});
        vecs.push_back('{8'h00, 8'h01, 1'b0, 1'b1, 0});
        vecs.push_back('{8'h20, 8'h00, 1'b1, 1'b0, 32});
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 1'b1, 0});
        vecs.push_back('{8'h1F, 8'h00, 1'b0, 1'b0, 31});
        vecs.push_back('{8'h05, 8'h00, 1'b1, 1'b0, 5});

        reset        = 1'b0;
        Start_i      = 1'b0;
        Byte_i       = 8'h00;
        Byte_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, Byte_ready_o}, 32'd0);
        check("rst_we", {31'd0, Mem_we_o}, 32'd0);
        check("rst_cpu", {31'd0, Cpu_rst_n_o}, 32'd0);
        check("rst_busy", {31'd0, Busy_o}, 32'd0);
        check("rst_done", {31'd0, Done_o}, 32'd0);
        check("rst_error", {31'd0, Error_o}, 32'd0);
        check("rst_addr", Mem_addr_o, TB_BASE);
        check("rst_wdata", Mem_wdata_o, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic load with exact write and release latency.
        img.delete();
        img.push_back(32'h0010_0513);
        img.push_back(32'h0020_0593);
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 4; k++) send_byte(8'((img[0] >> (8 * k)) & 32'hFF), 0);
        check("basic_w0_we", {31'd0, Mem_we_o}, 32'd1);
        for (int k = 0; k < 4; k++) send_byte(8'((img[1] >> (8 * k)) & 32'hFF), 0);
        check("basic_w1_we", {31'd0, Mem_we_o}, 32'd1);
        check("basic_w1_addr", Mem_addr_o, 32'h0040_0004);
        check("basic_w1_data", Mem_wdata_o, 32'h0020_0593);
        check("basic_early_done", {31'd0, Done_o}, 32'd0);
        @(negedge clk);
        check("basic_we_drop", {31'd0, Mem_we_o}, 32'd0);
        check("basic_done_n1", {31'd0, Done_o}, 32'd0);
        @(negedge clk);
        check("basic_done_n2", {31'd0, Done_o}, 32'd1);
        check("basic_cpu_n2", {31'd0, Cpu_rst_n_o}, 32'd1);
        compare_writes("basic", 2);

        // Start during COLLECT must be ignored.
        cap_addr.delete();
        cap_data.delete();
        img.delete();
        img.push_back($urandom);
        img.push_back($urandom);
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'(img[0] & 32'hFF), 0);
        send_byte(8'((img[0] >> 8) & 32'hFF), 0);
        Start_i = 1'b1;
        repeat (2) @(negedge clk);
        Start_i = 1'b0;
        send_byte(8'((img[0] >> 16) & 32'hFF), 0);
        send_byte(8'((img[0] >> 24) & 32'hFF), 0);
        for (int k = 0; k < 4; k++) send_byte(8'((img[1] >> (8 * k)) & 32'hFF), 0);
        wait_done_or_error();
        check("ignstart_done", {31'd0, Done_o}, 32'd1);
        compare_writes("ignstart", 2);

        foreach (vecs[i]) run_vector(i, vecs[i]);

        // Reset after two bytes of word 1, then a clean session.
        cap_addr.delete();
        cap_data.delete();
        img.delete();
        img.push_back($urandom);
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_image(1'b0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", {31'd0, Byte_ready_o}, 32'd0);
        check("mid_rst_busy", {31'd0, Busy_o}, 32'd0);
        check("mid_rst_cpu", {31'd0, Cpu_rst_n_o}, 32'd0);
        check("mid_rst_addr", Mem_addr_o, TB_BASE);
        check("mid_rst_wdata", Mem_wdata_o, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_nwrites", 32'(cap_addr.size()), 32'd1);
        cap_addr.delete();
        cap_data.delete();
        img.delete();
        img.push_back($urandom);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_image(1'b1);
        wait_done_or_error();
        check("post_rst_done", {31'd0, Done_o}, 32'd1);
        compare_writes("post_rst", 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
